// File: rtl/ysyx_22040365_wbu.sv
// Write-back unit: single-entry WB register, 32 x XLEN register file,
// and two combinational read ports with bypass from the pending entry.
module ysyx_22040365_wbu #(
    parameter int XLEN    = 64,
    parameter int NR_REGS = 32,
    parameter int AW      = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wen_rd,
    input  logic [AW-1:0]   ex_rd,
    input  logic            wb_stall,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [63:0]     retire_cnt
);

    logic            r_wb_valid;
    logic            r_wb_wen;
    logic [AW-1:0]   r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic [63:0]     r_retire_cnt;
    logic [XLEN-1:0] r_regs [NR_REGS];

    logic w_accept;
    logic w_retire;
    logic w_write;

    assign ex_ready = !r_wb_valid || !wb_stall;
    assign w_accept = ex_valid && ex_ready;
    assign w_retire = r_wb_valid && !wb_stall;
    assign w_write  = w_retire && r_wb_wen && (r_wb_rd != '0);

    // Accept may coincide with retire, which keeps throughput at one per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_wen   <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else if (w_accept) begin
            r_wb_valid <= 1'b1;
            r_wb_wen   <= wen_rd;
            r_wb_rd    <= ex_rd;
            r_wb_data  <= ex_result;
        end else if (w_retire) begin
            r_wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write) begin
            r_regs[r_wb_rd] <= r_wb_data;
        end
    end

    logic w_byp1;
    logic w_byp2;

    assign w_byp1 = r_wb_valid && r_wb_wen && (r_wb_rd == rs1_addr);
    assign w_byp2 = r_wb_valid && r_wb_wen && (r_wb_rd == rs2_addr);

    always_comb begin
        rs1_data = r_regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (w_byp1) begin
            rs1_data = r_wb_data;
        end
    end

    always_comb begin
        rs2_data = r_regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (w_byp2) begin
            rs2_data = r_wb_data;
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_ysyx_22040365_wbu.sv
// Directed bench for the write-back unit: per-cycle vector table
// plus a hand-written asynchronous reset sequence.
module tb_ysyx_22040365_wbu;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_result;
    logic        wen_rd;
    logic [4:0]  ex_rd;
    logic        wb_stall;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [63:0] retire_cnt;

    int checks;
    int failures;

    ysyx_22040365_wbu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_result  (ex_result),
        .wen_rd     (wen_rd),
        .ex_rd      (ex_rd),
        .wb_stall   (wb_stall),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [63:0] res;
        logic        wen;
        logic [4:0]  rd;
        logic        stall;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        e_rdy;
        logic [63:0] e_r1;
        logic [63:0] e_r2;
        logic        e_wbv;
        logic [63:0] e_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic vld, input logic [63:0] res, input logic wen,
        input logic [4:0] rd, input logic stall,
        input logic [4:0] a1, input logic [4:0] a2,
        input logic e_rdy, input logic [63:0] e_r1,
        input logic [63:0] e_r2, input logic e_wbv,
        input logic [63:0] e_cnt);
        vec_t v;
        v.vld = vld; v.res = res; v.wen = wen; v.rd = rd;
        v.stall = stall; v.a1 = a1; v.a2 = a2;
        v.e_rdy = e_rdy; v.e_r1 = e_r1; v.e_r2 = e_r2;
        v.e_wbv = e_wbv; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_valid  = v.vld;
        ex_result = v.res;
        wen_rd    = v.wen;
        ex_rd     = v.rd;
        wb_stall  = v.stall;
        rs1_addr  = v.a1;
        rs2_addr  = v.a2;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Each row: inputs for this cycle, expected outputs before its edge
        vecs[0]  = mk(1, 64'h1234, 1, 5, 0, 5, 0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 5, 0, 1, 64'h1234, 0, 1, 0);
        vecs[2]  = mk(1, 64'hDEADBEEF, 1, 0, 0, 5, 0, 1, 64'h1234, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 5, 1, 0, 64'h1234, 1, 1);
        vecs[4]  = mk(1, 64'h55, 0, 7, 0, 0, 7, 1, 0, 0, 0, 2);
        vecs[5]  = mk(0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 1, 2);
        vecs[6]  = mk(1, 64'h1, 1, 3, 0, 7, 3, 1, 0, 0, 0, 3);
        vecs[7]  = mk(1, 64'h2, 1, 3, 0, 0, 3, 1, 0, 64'h1, 1, 3);
        vecs[8]  = mk(1, 64'h3, 1, 3, 0, 0, 3, 1, 0, 64'h2, 1, 4);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 64'h3, 1, 5);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 64'h3, 0, 6);
        vecs[11] = mk(1, 64'hAA, 1, 9, 0, 9, 0, 1, 0, 0, 0, 6);
        vecs[12] = mk(1, 64'hBB, 1, 10, 1, 9, 10, 0, 64'hAA, 0, 1, 6);
        vecs[13] = mk(1, 64'hBB, 1, 10, 1, 9, 10, 0, 64'hAA, 0, 1, 6);
        vecs[14] = mk(1, 64'hBB, 1, 10, 1, 9, 10, 0, 64'hAA, 0, 1, 6);
        vecs[15] = mk(1, 64'hBB, 1, 10, 1, 9, 10, 0, 64'hAA, 0, 1, 6);
        vecs[16] = mk(1, 64'hBB, 1, 10, 0, 9, 10, 1, 64'hAA, 0, 1, 6);
        vecs[17] = mk(0, 0, 0, 0, 0, 9, 10, 1, 64'hAA, 64'hBB, 1, 7);
        vecs[18] = mk(1, 64'h77, 1, 4, 1, 9, 10, 1, 64'hAA, 64'hBB, 0, 8);
        vecs[19] = mk(0, 0, 0, 0, 1, 4, 3, 0, 64'h77, 64'h3, 1, 8);

        rst_n     = 1'b0;
        ex_valid  = 1'b0;
        ex_result = '0;
        wen_rd    = 1'b0;
        ex_rd     = '0;
        wb_stall  = 1'b0;
        rs1_addr  = 5'd5;
        rs2_addr  = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        chk("rst_cnt", retire_cnt, 64'd0);
        chk("rst_rs1", rs1_data, 64'd0);
        chk("rst_ready", {63'd0, ex_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_ready", i), {63'd0, ex_ready},
                {63'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_rs1", i), rs1_data, vecs[i].e_r1);
            chk($sformatf("v%0d_rs2", i), rs2_data, vecs[i].e_r2);
            chk($sformatf("v%0d_wbv", i), {63'd0, wb_valid},
                {63'd0, vecs[i].e_wbv});
            chk($sformatf("v%0d_cnt", i), retire_cnt, vecs[i].e_cnt);
        end

        // Entry {x4,0x77} is held by stall; reset lands mid-cycle
        @(posedge clk);
        #1;
        chk("hold_wb_rd", {59'd0, wb_rd}, 64'd4);
        chk("hold_wb_data", wb_data, 64'h77);
        chk("hold_cnt", retire_cnt, 64'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("arst_cnt", retire_cnt, 64'd0);
        chk("arst_rs1_x4", rs1_data, 64'd0);
        chk("arst_rs2_x3", rs2_data, 64'd0);
        @(negedge clk);
        wb_stall = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("post_cnt", retire_cnt, 64'd0);
        chk("post_rs1_x4", rs1_data, 64'd0);
        rs1_addr = 5'd9;
        rs2_addr = 5'd10;
        #1;
        chk("post_rs1_x9", rs1_data, 64'd0);
        chk("post_rs2_x10", rs2_data, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
